avalon_bidir_pio: RTL
=====================

Name: avalon_bidir_pio

Overview:
- Parametrised Avalon-MM bidirectional PIO for bit-banged buses (I2C SDA/SCL, 1-wire, GPIO banks) on the Nios II system.
- Provides WIDTH independent tri-state pins with a per-bit direction register and atomic set/clear of output bits.
- Samples inputs through a synchroniser, captures edges per bit, and raises a maskable interrupt, so software no longer needs one single-bit core per pin.

Parameters:
- WIDTH, 8, number of bidirectional pins (1..32).
- RESET_OUT, 0, reset value of the output data register (WIDTH bits).
- RESET_DIR, 0, reset value of the direction register; 1 = drive, 0 = high-Z.
- EDGE_TYPE, 0, capture mode: 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits [WIDTH-1:0] used.
- readdata  out  32  registered read data; upper bits zero.
- irq  out  1  level interrupt, active high.
- bidir_port  inout  WIDTH  external pins.

Behaviour:
- Reset: reset_n asynchronous, active-low; clock clk.
- Reset values:
  - data_out = RESET_OUT, data_dir = RESET_DIR, irq_mask = 0, edge_cap = 0.
  - Synchroniser stages and the previous-sample register = 0.
  - readdata = 0, irq = 0.
- Pin drive: bidir_port[i] = data_dir[i] ? data_out[i] : Z.
- Input path:
  - Raw pin value passes through SYNC_STAGES flops to give sync_in.
  - A further register holds prev_in.
  - Edge detect: rising = sync_in & ~prev_in; falling = ~sync_in & prev_in; any = sync_in ^ prev_in.
  - After reset, prev_in = 0, so a pin held high produces one rising edge once the synchroniser fills (expected; software clears edge_cap at init).
- Register map (a write is chipselect & ~write_n):
  - 0 DATA: read sync_in; write loads data_out.
  - 1 DIR: read/write data_dir.
  - 2 IRQMASK: read/write irq_mask.
  - 3 EDGECAP: read edge_cap; write-1-to-clear per bit.
  - 4 OUTSET: write data_out |= writedata; reads 0.
  - 5 OUTCLR: write data_out &= ~writedata; reads 0.
  - 6, 7: reserved; writes ignored, reads 0.
- Read latency: readdata <= mux(address) on every clk edge regardless of chipselect, so data is valid on the cycle after address is presented. Reads have no side effects.
- Edge capture: edge_cap[i] is set on a detected edge and held until cleared.
  - An edge in the same cycle as a write-1-to-clear of that bit leaves the bit SET (set wins).
- irq: registered, irq <= |(edge_cap & irq_mask); one cycle after edge_cap/irq_mask change.
- A write to DIR takes effect on the pin the cycle after the write; same for DATA, OUTSET and OUTCLR.
- An edge on the pin appears in edge_cap SYNC_STAGES+1 cycles after the pin change (rising-edge sampled).
- Reset mid-operation: all state returns to reset values immediately; pins return to RESET_DIR drive state asynchronously.

Decomposition:
- Package avalon_pio_pkg holds:
  - register address constants ADDR_DATA..ADDR_OUTCLR;
  - EDGE_RISING / EDGE_FALLING / EDGE_ANY encodings;
  - the readdata width constant 32.
- Sub-module pio_sync: a WIDTH-bit, SYNC_STAGES-deep synchroniser with async reset, instantiated once.
- Register file, edge detect and irq logic stay in the top level.

Test Plan:
- Reset with RESET_OUT=8'hA5, RESET_DIR=8'h0F -> pins [3:0] drive 4'h5, pins [7:4] Z; readdata=0; irq=0.
- Write DIR=8'hFF, DATA=8'h3C, then OUTSET=8'h01, then OUTCLR=8'h0C -> pins show 3C, then 3D, then 31, each one cycle after its write.
- DIR=0; external driver sets pin 2 high; read DATA (address 0) -> 32'h00000004 appears no earlier than SYNC_STAGES+1 cycles after the pin change. Read DIR -> 0.
- EDGE_TYPE=0, IRQMASK=8'h04; pulse pin 2 0->1 -> EDGECAP=8'h04 and irq=1. Write EDGECAP 8'h04 -> edge_cap=0 and irq=0 one cycle later. With IRQMASK=0, the same edge sets edge_cap but irq stays 0.
- Simultaneous event: schedule a rising edge on pin 5 in the exact cycle of a write-1-to-clear to EDGECAP bit 5 -> edge_cap[5] remains 1.
- Assert reset_n low mid-transfer with DIR=FF -> pins go to RESET_DIR state without waiting for clk; edge_cap and irq clear; read of address 6 afterwards -> 0.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM bidirectional PIO: register map,
// edge-capture mode encodings and the bus data width.
package avalon_pio_pkg;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned RDATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync.sv
// WIDTH-bit, STAGES-deep input synchroniser with asynchronous active-low reset.
module pio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    // Stage 0 takes the raw pins; each later stage takes its predecessor.
    always_comb begin
        stage_d = {stage_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/avalon_bidir_pio.sv
// Avalon-MM bidirectional PIO: per-bit direction, atomic set/clear of outputs,
// synchronised inputs with per-bit edge capture and a maskable level interrupt.
module avalon_bidir_pio
    import avalon_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [RDATA_W-1:0] writedata,
    output logic [RDATA_W-1:0] readdata,
    output logic               irq,
    inout  wire  [WIDTH-1:0]   bidir_port
);

    logic [WIDTH-1:0]   out_q,  out_d;
    logic [WIDTH-1:0]   dir_q,  dir_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   cap_q,  cap_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [RDATA_W-1:0] rdata_q, rdata_d;
    logic               irq_q,  irq_d;

    logic [WIDTH-1:0]   sync_in;
    logic [WIDTH-1:0]   edge_vec;
    logic [WIDTH-1:0]   wdata;
    logic               wr_en;
    logic               unused_wdata;

    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;

    // Pins drive only where the direction bit is set; dir_q resets
    // asynchronously, so the pads follow reset without a clock.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bidir_port),
        .dout    (sync_in)
    );

    always_comb begin
        edge_vec = sync_in & ~prev_q;
        case (EDGE_TYPE)
            EDGE_FALLING: edge_vec = ~sync_in & prev_q;
            EDGE_ANY:     edge_vec = sync_in ^ prev_q;
            default:      edge_vec = sync_in & ~prev_q;
        endcase
    end

    // Register file writes, edge capture (a new edge beats a same-cycle
    // clear), interrupt and the registered read mux.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        cap_d   = cap_q;
        prev_d  = sync_in;
        irq_d   = |(cap_q & mask_q);
        rdata_d = '0;

        if (wr_en) begin
            case (address)
                ADDR_DATA:    out_d  = wdata;
                ADDR_DIR:     dir_d  = wdata;
                ADDR_IRQMASK: mask_d = wdata;
                ADDR_EDGECAP: cap_d  = cap_q & ~wdata;
                ADDR_OUTSET:  out_d  = out_q | wdata;
                ADDR_OUTCLR:  out_d  = out_q & ~wdata;
                default:      ;
            endcase
        end
        cap_d = cap_d | edge_vec;

        case (address)
            ADDR_DATA:    rdata_d = RDATA_W'(sync_in);
            ADDR_DIR:     rdata_d = RDATA_W'(dir_q);
            ADDR_IRQMASK: rdata_d = RDATA_W'(mask_q);
            ADDR_EDGECAP: rdata_d = RDATA_W'(cap_q);
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= RESET_OUT;
            dir_q   <= RESET_DIR;
            mask_q  <= '0;
            cap_q   <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            prev_q  <= prev_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
